// File: rtl/switch_nxn_param_pkg.sv
// Shared types and helpers for the parametrised NxN FIFO switch:
// FSM state encoding, log2 sizing helper and threshold reset defaults.
package switch_nxn_param_pkg;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int defaultHighTh(input int depth);
        return depth - 1;
    endfunction

    localparam int DEFAULT_LOW_TH = 1;

endpackage

// File: rtl/fifo_param.sv
// Synchronous FIFO with a show-ahead head word (data_out is the word the
// next pop removes); used for both the input and the output banks.
module fifo_param
    import switch_nxn_param_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wrPtr_q;
    logic [AW-1:0]     rdPtr_q;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              doPush;
    logic              doPop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign data_out = mem_q[rdPtr_q];
    assign doPop    = pop && !empty;
    // a full FIFO still takes a word when the same edge frees a slot
    assign doPush   = push && (!full || doPop);

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_in;
    end

endmodule

// File: rtl/switch_nxn_param.sv
// NCH x NCH FIFO switch: input FIFOs, arbiter, destination demux, output FIFOs,
// almost-full back-pressure and delivered-word counters. Define STRICT_PRIORITY_EN
// for fixed lowest-index-wins arbitration instead of round-robin.
module switch_nxn_param
    import switch_nxn_param_pkg::*;
#(
    parameter int DATA_W  = 10,
    parameter int NCH     = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 5,
    localparam int DEST_W = clog2(NCH),
    localparam int AW     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [AW:0]           high_th,
    input  logic [AW:0]           low_th,
    input  logic [NCH-1:0]        push,
    input  logic [NCH*DATA_W-1:0] data_in,
    input  logic [NCH-1:0]        pop,
    output logic [NCH*DATA_W-1:0] data_out,
    input  logic                  req,
    input  logic [DEST_W-1:0]     idx,
    output logic [CNT_W-1:0]      cnt_out,
    output logic                  cnt_valid,
    output logic [NCH-1:0]        in_full,
    output logic [NCH-1:0]        out_almost_full,
    output logic [NCH-1:0]        out_almost_empty,
    output logic                  idle
);

    localparam logic [AW:0] HIGH_RST = (AW+1)'(defaultHighTh(DEPTH));
    localparam logic [AW:0] LOW_RST  = (AW+1)'(DEFAULT_LOW_TH);

    state_e              state_q, state_d;
    logic [AW:0]         highTh_q, lowTh_q;
    logic [DATA_W-1:0]   inHead   [NCH];
    logic [AW:0]         inCount  [NCH];
    logic [DATA_W-1:0]   outHead  [NCH];
    logic [AW:0]         outCount [NCH];
    logic [NCH-1:0]      inEmpty, outEmpty, outFull;
    logic [NCH-1:0]      eligible, inPop, outPush;
    logic [DEST_W-1:0]   headDest, grantIdx, xferDest;
    logic                grantValid, anyInput, allEmpty;
    logic [DATA_W-1:0]   xferWord;
    logic [DATA_W-1:0]   dataOut_q [NCH];
    logic [CNT_W-1:0]    cnt_q     [NCH];
    logic [CNT_W-1:0]    cntOut_q;
    logic                cntValid_q;

    assign anyInput = ~&inEmpty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:    state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (anyInput)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (!anyInput) state_d = ST_IDLE;
            default:   state_d = ST_RST;
        endcase
        if (init) state_d = ST_INIT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RST;
            highTh_q <= HIGH_RST;
            lowTh_q  <= LOW_RST;
        end else begin
            state_q <= state_d;
            if (init || state_q == ST_INIT) begin
                highTh_q <= high_th;
                lowTh_q  <= low_th;
            end
        end
    end

    // The full check only matters when high_th exceeds DEPTH; it keeps a word
    // from being moved into an output that cannot take it.
    always_comb begin
        eligible = '0;
        headDest = '0;
        for (int i = 0; i < NCH; i++) begin
            headDest    = inHead[i][DATA_W-1 -: DEST_W];
            eligible[i] = !inEmpty[i] && !out_almost_full[headDest] && !outFull[headDest];
        end
    end

`ifdef STRICT_PRIORITY_EN
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        if (state_q == ST_ACTIVE) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (eligible[k]) begin
                    grantValid = 1'b1;
                    grantIdx   = DEST_W'(k);
                end
            end
        end
    end
`else
    logic [DEST_W-1:0] rrPtr_q;
    logic [DEST_W-1:0] cand;

    // Scanning backwards leaves the first eligible channel after rrPtr_q as the winner.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        if (state_q == ST_ACTIVE) begin
            for (int k = NCH; k >= 1; k--) begin
                cand = DEST_W'((int'(rrPtr_q) + k) % NCH);
                if (eligible[cand]) begin
                    grantValid = 1'b1;
                    grantIdx   = cand;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr_q <= DEST_W'(NCH - 1);
        end else if (grantValid) begin
            rrPtr_q <= grantIdx;
        end
    end
`endif

    always_comb begin
        inPop = '0;
        if (grantValid) inPop[grantIdx] = 1'b1;
    end

    assign xferWord = inHead[grantIdx];
    assign xferDest = xferWord[DATA_W-1 -: DEST_W];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign outPush[g] = grantValid && (xferDest == DEST_W'(g));

        fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[g]),
            .pop      (inPop[g]),
            .data_in  (data_in[g*DATA_W +: DATA_W]),
            .data_out (inHead[g]),
            .count    (inCount[g]),
            .full     (in_full[g]),
            .empty    (inEmpty[g])
        );

        fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (outPush[g]),
            .pop      (pop[g]),
            .data_in  (xferWord),
            .data_out (outHead[g]),
            .count    (outCount[g]),
            .full     (outFull[g]),
            .empty    (outEmpty[g])
        );

        assign out_almost_full[g]          = (outCount[g] >= highTh_q);
        assign out_almost_empty[g]         = (outCount[g] <= lowTh_q);
        assign data_out[g*DATA_W +: DATA_W] = dataOut_q[g];
    end

    always_comb begin
        allEmpty = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (inCount[i] != '0 || outCount[i] != '0) allEmpty = 1'b0;
        end
    end

    assign idle = (state_q == ST_IDLE) && allEmpty;

    // A counter read samples the value before any pop on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NCH; j++) begin
                dataOut_q[j] <= '0;
                cnt_q[j]     <= '0;
            end
            cntOut_q   <= '0;
            cntValid_q <= 1'b0;
        end else begin
            for (int j = 0; j < NCH; j++) begin
                if (pop[j] && !outEmpty[j]) begin
                    dataOut_q[j] <= outHead[j];
                    cnt_q[j]     <= cnt_q[j] + CNT_W'(1);
                end
            end
            cntValid_q <= req;
            if (req) cntOut_q <= cnt_q[idx];
        end
    end

    assign cnt_out   = cntOut_q;
    assign cnt_valid = cntValid_q;

endmodule

// File: tb/tb_switch_nxn_param.sv
// Scoreboard bench for switch_nxn_param: a queue-level reference model predicts
// popped words, counter reads and flags; a monitor compares them on the falling edge.
module tb_switch_nxn_param;

    localparam int DATA_W = 10;
    localparam int NCH    = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 5;
    localparam int DEST_W = 2;
    localparam int AW     = 3;

    typedef logic [DATA_W-1:0] word_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  init;
    logic [AW:0]           high_th, low_th;
    logic [NCH-1:0]        push, pop;
    logic [NCH*DATA_W-1:0] data_in, data_out;
    logic                  req;
    logic [DEST_W-1:0]     idx;
    logic [CNT_W-1:0]      cnt_out;
    logic                  cnt_valid;
    logic [NCH-1:0]        in_full, out_almost_full, out_almost_empty;
    logic                  idle;

    always #5 clk = ~clk;

    switch_nxn_param dut (
        .clk              (clk),
        .reset            (reset),
        .init             (init),
        .high_th          (high_th),
        .low_th           (low_th),
        .push             (push),
        .data_in          (data_in),
        .pop              (pop),
        .data_out         (data_out),
        .req              (req),
        .idx              (idx),
        .cnt_out          (cnt_out),
        .cnt_valid        (cnt_valid),
        .in_full          (in_full),
        .out_almost_full  (out_almost_full),
        .out_almost_empty (out_almost_empty),
        .idle             (idle)
    );

    typedef struct {
        int    due;
        int    ch;
        word_t word;
    } data_exp_t;

    typedef struct {
        int             due;
        logic [NCH-1:0] inFull;
        logic [NCH-1:0] aFull;
        logic [NCH-1:0] aEmpty;
        logic           idleExp;
        logic           cv;
        logic [CNT_W-1:0] cnt;
    } flag_exp_t;

    data_exp_t dataQ[$];
    flag_exp_t flagQ[$];
    int cyc = 0;
    int checks = 0;
    int passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain queues, a state number, thresholds, grant history, pop totals.
    word_t inQ  [NCH][$];
    word_t outQ [NCH][$];
    int    mState;          // 0 reset, 1 init, 2 idle, 3 active
    int    hiTh, loTh, lastGrant;
    int    delivered [NCH];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            inQ[i].delete();
            outQ[i].delete();
            delivered[i] = 0;
        end
        mState    = 0;
        hiTh      = DEPTH - 1;
        loTh      = 1;
        lastGrant = NCH - 1;
        dataQ.delete();
        flagQ.delete();
    endtask

    function automatic int destOf(input word_t w);
        return int'(w >> (DATA_W - DEST_W));
    endfunction

    task automatic modelStep();
        bit        anyIn, hasGrant, allEmpty;
        int        grant, c, d, ns;
        word_t     w;
        data_exp_t de;
        flag_exp_t fe;
        anyIn = 0;
        for (int i = 0; i < NCH; i++) if (inQ[i].size() > 0) anyIn = 1;
        hasGrant = 0;
        grant    = 0;
        if (mState == 3) begin
            for (int k = 0; k < NCH; k++) begin
`ifdef STRICT_PRIORITY_EN
                c = k;
`else
                c = (lastGrant + 1 + k) % NCH;
`endif
                if (!hasGrant && inQ[c].size() > 0) begin
                    d = destOf(inQ[c][0]);
                    if (outQ[d].size() < hiTh && outQ[d].size() < DEPTH) begin
                        hasGrant = 1;
                        grant    = c;
                    end
                end
            end
        end
        fe.cv  = req;
        fe.cnt = req ? CNT_W'(delivered[idx] % (1 << CNT_W)) : '0;
        for (int j = 0; j < NCH; j++) begin
            if (pop[j] && outQ[j].size() > 0) begin
                de.due  = cyc + 1;
                de.ch   = j;
                de.word = outQ[j].pop_front();
                dataQ.push_back(de);
                delivered[j]++;
            end
        end
        if (hasGrant) begin
            w = inQ[grant].pop_front();
            outQ[destOf(w)].push_back(w);
            lastGrant = grant;
        end
        for (int i = 0; i < NCH; i++) begin
            if (push[i] && inQ[i].size() < DEPTH) inQ[i].push_back(data_in[i*DATA_W +: DATA_W]);
        end
        if (init)             ns = 1;
        else if (mState == 0) ns = 1;
        else if (mState == 1) ns = 2;
        else                  ns = anyIn ? 3 : 2;
        if (init || mState == 1) begin
            hiTh = int'(high_th);
            loTh = int'(low_th);
        end
        mState = ns;
        allEmpty = 1;
        for (int i = 0; i < NCH; i++) begin
            fe.inFull[i] = (inQ[i].size() == DEPTH);
            fe.aFull[i]  = (outQ[i].size() >= hiTh);
            fe.aEmpty[i] = (outQ[i].size() <= loTh);
            if (inQ[i].size() > 0 || outQ[i].size() > 0) allEmpty = 0;
        end
        fe.idleExp = (mState == 2) && allEmpty;
        fe.due     = cyc + 1;
        flagQ.push_back(fe);
    endtask

    // Monitor: compares everything whose due cycle has arrived.
    always @(negedge clk) begin
        data_exp_t de;
        flag_exp_t fe;
        while (dataQ.size() > 0 && dataQ[0].due <= cyc) begin
            de = dataQ.pop_front();
            checkOutput($sformatf("data_out[%0d]", de.ch),
                        32'(data_out[de.ch*DATA_W +: DATA_W]), 32'(de.word));
        end
        while (flagQ.size() > 0 && flagQ[0].due <= cyc) begin
            fe = flagQ.pop_front();
            checkOutput("in_full", 32'(in_full), 32'(fe.inFull));
            checkOutput("out_almost_full", 32'(out_almost_full), 32'(fe.aFull));
            checkOutput("out_almost_empty", 32'(out_almost_empty), 32'(fe.aEmpty));
            checkOutput("idle", 32'(idle), 32'(fe.idleExp));
            checkOutput("cnt_valid", 32'(cnt_valid), 32'(fe.cv));
            if (fe.cv) checkOutput("cnt_out", 32'(cnt_out), 32'(fe.cnt));
        end
    end

    task automatic applyStimulus(input logic [NCH-1:0] p, input logic [NCH*DATA_W-1:0] d,
                                 input logic [NCH-1:0] pp, input logic r, input logic [DEST_W-1:0] ix);
        push    = p;
        data_in = d;
        pop     = pp;
        req     = r;
        idx     = ix;
        modelStep();
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, '0, 1'b0, '0);
    endtask

    function automatic word_t mk(input int dest, input int payload);
        return word_t'((dest << (DATA_W - DEST_W)) | (payload & 8'hFF));
    endfunction

    function automatic logic [NCH*DATA_W-1:0] packOne(input int ch, input word_t w);
        logic [NCH*DATA_W-1:0] v;
        v = '0;
        v[ch*DATA_W +: DATA_W] = w;
        return v;
    endfunction

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " data_out"}, 32'(data_out), 32'(0));
        checkOutput({tag, " cnt_out"}, 32'(cnt_out), 32'(0));
        checkOutput({tag, " cnt_valid"}, 32'(cnt_valid), 32'(0));
        checkOutput({tag, " in_full"}, 32'(in_full), 32'(0));
        checkOutput({tag, " out_almost_full"}, 32'(out_almost_full), 32'(0));
        checkOutput({tag, " out_almost_empty"}, 32'(out_almost_empty), 32'(4'hF));
        checkOutput({tag, " idle"}, 32'(idle), 32'(0));
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : stim
        logic [NCH*DATA_W-1:0] dv;
        logic [NCH-1:0]        pv;
        init = 1'b1; high_th = 4'd6; low_th = 4'd1;
        push = '0; pop = '0; data_in = '0; req = 1'b0; idx = '0;
        modelReset();
        #1 reset = 1'b1;
        #1 checkResetValues("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idleCycles(3);
        init = 1'b0;

        // single word to output 0, then read its counter
        applyStimulus(4'b0001, packOne(0, mk(0, 8'hAB)), '0, 1'b0, '0);
        idleCycles(3);
        for (int i = 0; i < 3; i++) applyStimulus('0, '0, 4'b0001, 1'b0, '0);
        applyStimulus('0, '0, '0, 1'b1, 2'd0);
        idleCycles(2);

        // all inputs target output 2, two rounds
        applyStimulus(4'hF, {mk(2, 8'h13), mk(2, 8'h12), mk(2, 8'h11), mk(2, 8'h10)}, '0, 1'b0, '0);
        applyStimulus(4'hF, {mk(2, 8'h23), mk(2, 8'h22), mk(2, 8'h21), mk(2, 8'h20)}, '0, 1'b0, '0);
        idleCycles(8);
        for (int i = 0; i < 10; i++) applyStimulus('0, '0, 4'b0100, 1'b0, '0);

        // back-pressure on output 1 while output 3 keeps flowing
        for (int i = 0; i < 6; i++) applyStimulus(4'b0001, packOne(0, mk(1, 8'h30 + i)), '0, 1'b0, '0);
        idleCycles(3);
        for (int i = 0; i < 2; i++)
            applyStimulus(4'b0110, packOne(1, mk(1, 8'h40 + i)) | packOne(2, mk(3, 8'h50 + i)), '0, 1'b0, '0);
        idleCycles(4);
        applyStimulus('0, '0, 4'b0010, 1'b0, '0);
        idleCycles(3);
        for (int i = 0; i < 20; i++) applyStimulus('0, '0, 4'hF, 1'b0, '0);

        // overfill input 2 while arbitration is held off
        init = 1'b1;
        for (int i = 0; i < 9; i++) applyStimulus(4'b0100, packOne(2, mk(i % 4, 8'h60 + i)), '0, 1'b0, '0);
        init = 1'b0;
        for (int i = 0; i < 25; i++) applyStimulus('0, '0, 4'hF, 1'b0, '0);

        // forty deliveries on output 3 wrap the 5-bit counter
        doReset();
        init = 1'b1; high_th = 4'd6; low_th = 4'd1;
        idleCycles(2);
        init = 1'b0;
        for (int k = 0; k < 40; k++)
            applyStimulus(NCH'(1 << (k % 4)), packOne(k % 4, mk(3, k)), 4'b1000, 1'b0, '0);
        for (int i = 0; i < 15; i++) applyStimulus('0, '0, 4'b1000, 1'b0, '0);
        applyStimulus('0, '0, '0, 1'b1, 2'd3);
        idleCycles(2);

        // randomized traffic, occasional re-init with new thresholds
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) dv[c*DATA_W +: DATA_W] = word_t'($urandom);
            pv = NCH'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                init    = 1'b1;
                high_th = 4'($urandom_range(2, 10));
                low_th  = 4'($urandom_range(0, 7));
            end else begin
                init = 1'b0;
            end
            applyStimulus(pv, dv, NCH'($urandom), 1'($urandom_range(0, 3) == 0), DEST_W'($urandom));
        end
        init = 1'b0;
        for (int i = 0; i < 30; i++) applyStimulus('0, '0, 4'hF, 1'b0, '0);

        // asynchronous reset while words are in flight
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NCH; c++) dv[c*DATA_W +: DATA_W] = word_t'($urandom);
            applyStimulus(4'hF, dv, '0, 1'b0, '0);
        end
        applyStimulus('0, '0, '0, 1'b1, 2'd1);
        push = '0; pop = '0; req = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        modelReset();
        #1 checkResetValues("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idleCycles(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
